// File: rtl/c2f_multi_ring_fetch_pkg.sv
// Shared types for the multi-ring CPU-to-FPGA fetcher:
// descriptor layout, FSM states, ID constants, width helpers.
package c2f_multi_ring_fetch_pkg;

  localparam int DESC_W = 174;
  localparam logic [7:0] DONE_ID_DEF = 8'hFD;

  // Field order fixes the bit offsets:
  // src [63:0], dst [127:64], dwords [145:128],
  // imm [146], single [147], id [158:151].
  typedef struct packed {
    logic [14:0] rsv1;
    logic [7:0]  id;
    logic [2:0]  rsv0;
    logic        single;
    logic        imm;
    logic [17:0] dwords;
    logic [63:0] dst;
    logic [63:0] src;
  } desc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_DESC,
    S_WAIT
  } c2f_state_t;

  // Bits needed to hold 0..m lines.
  function automatic int xfer_w(input int m);
    return $clog2(m) + 1;
  endfunction

  // Channel index width, at least 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c2f_multi_ring_fetch_if.sv
// Mover/stream bundle of the ring fetcher.
// master = fetcher side; slave = movers and downstream sink.
interface c2f_multi_ring_fetch_if
  import c2f_multi_ring_fetch_pkg::*;
#(
  parameter int CHW = 2
);
  logic              rddm_desc_ready;
  logic              rddm_desc_valid;
  logic [DESC_W-1:0] rddm_desc_data;
  logic              wrdm_prio_ready;
  logic              wrdm_prio_valid;
  logic [DESC_W-1:0] wrdm_prio_data;
  logic              c2f_write;
  logic [511:0]      c2f_writedata;
  logic              out_valid;
  logic [511:0]      out_data;
  logic [CHW-1:0]    out_ch;

  modport master (
    input  rddm_desc_ready,
    output rddm_desc_valid, rddm_desc_data,
    input  wrdm_prio_ready,
    output wrdm_prio_valid, wrdm_prio_data,
    input  c2f_write, c2f_writedata,
    output out_valid, out_data, out_ch
  );

  modport slave (
    output rddm_desc_ready,
    input  rddm_desc_valid, rddm_desc_data,
    output wrdm_prio_ready,
    input  wrdm_prio_valid, wrdm_prio_data,
    output c2f_write, c2f_writedata,
    input  out_valid, out_data, out_ch
  );
endinterface

// File: rtl/c2f_multi_ring_fetch_arb.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Ports: req (N), ptr (W) in; gnt (W), hit out.
module c2f_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         hit
);
  // Scan from the far end so the nearest
  // requester after ptr is written last.
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        hit = 1'b1;
        gnt = W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/c2f_multi_ring_fetch.sv
// Round-robin fetcher over NUM_CH host rings: data descriptor,
// head writeback, tagged forwarding of returned lines.
// Ports: ch_en/tail/kmem_addr/head_wb_addr in, head out,
// meta_cnt in, stray_wr_cnt out, bus = mover/stream bundle.
module c2f_multi_ring_fetch
  import c2f_multi_ring_fetch_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          RB_AWIDTH    = 10,
  parameter int          MAX_XFER     = 64,
  parameter int          META_OCCUP   = 480,
  parameter logic [31:0] EP_BASE_ADDR = 32'h0004_0000,
  parameter logic [7:0]  DONE_ID      = DONE_ID_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH*RB_AWIDTH-1:0] tail,
  input  logic [NUM_CH*64-1:0]        kmem_addr,
  input  logic [NUM_CH*64-1:0]        head_wb_addr,
  output logic [NUM_CH*RB_AWIDTH-1:0] head,
  input  logic [9:0]                  meta_cnt,
  output logic [15:0]                 stray_wr_cnt,
  c2f_multi_ring_fetch_if.master      bus
);
  localparam int CHW   = idx_w(NUM_CH);
  localparam int XW    = xfer_w(MAX_XFER);
  localparam int AW    = RB_AWIDTH;
  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] tail_a [NUM_CH];
  logic [AW-1:0] head_q [NUM_CH];
  logic [63:0]   kmem_a [NUM_CH];
  logic [63:0]   wb_a   [NUM_CH];
  logic [NUM_CH-1:0] req;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign tail_a[i] = tail[i*AW +: AW];
    assign kmem_a[i] = kmem_addr[i*64 +: 64];
    assign wb_a[i]   = head_wb_addr[i*64 +: 64];
    assign head[i*AW +: AW] = head_q[i];
    assign req[i] = ch_en[i] && (tail_a[i] != head_q[i]);
  end

  c2f_state_t    state, state_nx;
  logic [CHW-1:0] ptr, ch, gnt;
  logic          hit;
  logic [XW-1:0] xfer, wr_cnt;
  logic [15:0]   stray;
  logic          rddm_v, wrdm_v, out_v;
  desc_t         rddm_d, wrdm_d, dd, wd;
  logic [511:0]  out_d;
  logic [CHW-1:0] out_c;

  c2f_rr_arbiter #(.N(NUM_CH), .W(CHW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .hit (hit)
  );

  // Grant size: min(avail, MAX_XFER, lines to ring end).
  logic [AW-1:0] avail;
  logic [AW:0]   room, lim;
  always_comb begin
    avail = tail_a[gnt] - head_q[gnt];
    room  = (AW+1)'(DEPTH) - {1'b0, head_q[gnt]};
    lim   = {1'b0, avail};
    if (lim > (AW+1)'(MAX_XFER))
      lim = (AW+1)'(MAX_XFER);
    if (lim > room)
      lim = room;
  end

  logic credit_ok;
  assign credit_ok =
    (int'(xfer) + int'(meta_cnt)) < META_OCCUP;

  logic [AW-1:0] new_head;
  assign new_head = head_q[ch] + AW'(xfer);

  always_comb begin
    dd        = '0;
    dd.src    = kmem_a[ch] + {46'd0, head_q[ch], 6'd0};
    dd.dst    = {32'd0, EP_BASE_ADDR};
    dd.dwords = 18'({xfer, 4'd0});
    dd.id     = 8'(ch);
    wd        = '0;
    wd.src    = 64'(new_head);
    wd.dst    = wb_a[ch];
    wd.dwords = 18'd1;
    wd.imm    = 1'b1;
    wd.id     = DONE_ID;
  end

  logic active;
  assign active = (state == S_DESC) ||
                  (state == S_WAIT);

  // Writeback counts as consumed once it left
  // or is being taken this cycle.
  logic wb_ok;
  assign wb_ok = !wrdm_v || bus.wrdm_prio_ready;

  logic take, issue, fire, finish;
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    issue    = 1'b0;
    fire     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      S_IDLE: if (hit) begin
        take     = 1'b1;
        state_nx = S_CREDIT;
      end
      S_CREDIT: if (credit_ok) begin
        issue    = 1'b1;
        state_nx = S_DESC;
      end
      S_DESC: if (bus.rddm_desc_ready) begin
        fire     = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: if (wb_ok && wr_cnt == xfer) begin
        finish   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      ch     <= '0;
      xfer   <= '0;
      wr_cnt <= '0;
      stray  <= '0;
      rddm_v <= 1'b0;
      rddm_d <= '0;
      wrdm_v <= 1'b0;
      wrdm_d <= '0;
      out_v  <= 1'b0;
      out_d  <= '0;
      out_c  <= '0;
      for (int i = 0; i < NUM_CH; i++)
        head_q[i] <= '0;
    end else begin
      if (take) begin
        ch     <= gnt;
        xfer   <= XW'(lim);
        wr_cnt <= '0;
      end else if (active && bus.c2f_write) begin
        wr_cnt <= wr_cnt + XW'(1);
      end
      if (!active && bus.c2f_write &&
          stray != 16'hFFFF)
        stray <= stray + 16'd1;
      if (issue) begin
        rddm_v <= 1'b1;
        rddm_d <= dd;
      end
      if (fire) begin
        rddm_v     <= 1'b0;
        wrdm_v     <= 1'b1;
        wrdm_d     <= wd;
        head_q[ch] <= new_head;
      end else if (wrdm_v && bus.wrdm_prio_ready) begin
        wrdm_v <= 1'b0;
      end
      if (finish)
        ptr <= (ch == CHW'(NUM_CH - 1)) ?
               '0 : ch + CHW'(1);
      out_v <= active && bus.c2f_write;
      out_d <= bus.c2f_writedata;
      out_c <= ch;
    end
  end

  assign bus.rddm_desc_valid = rddm_v;
  assign bus.rddm_desc_data  = rddm_d;
  assign bus.wrdm_prio_valid = wrdm_v;
  assign bus.wrdm_prio_data  = wrdm_d;
  assign bus.out_valid       = out_v;
  assign bus.out_data        = out_d;
  assign bus.out_ch          = out_c;
  assign stray_wr_cnt        = stray;

endmodule
